// File: rtl/mtr_pkg.sv
// mtr_pkg: shared types and constants for the motor ramp block.
//   ramp_state_t : per-side FSM state (TRACK, HOLD, STOP)
//   duty_t       : signed duty / speed word
//   clamp_target : folds -2048 onto -2047 and masks the demand with `moving`
package mtr_pkg;

  localparam int unsigned DUTY_W   = 12;
  localparam int          DUTY_MAX = 2047;
  localparam int          DUTY_MIN = -2047;
  localparam int unsigned FAST_DIV = 16;

  typedef enum logic [1:0] {
    TRACK = 2'd0,
    HOLD  = 2'd1,
    STOP  = 2'd2
  } ramp_state_t;

  typedef logic signed [DUTY_W-1:0] duty_t;

  // Symmetric clamp of a raw demand, zeroed when the robot is not moving.
  function automatic duty_t clamp_target(input duty_t spd, input logic moving);
    if (!moving) begin
      return '0;
    end else if (spd < duty_t'(DUTY_MIN)) begin
      return duty_t'(DUTY_MIN);
    end else if (spd > duty_t'(DUTY_MAX)) begin
      return duty_t'(DUTY_MAX);
    end
    return spd;
  endfunction

endpackage

// File: rtl/mtr_ramp_side.sv
// mtr_ramp_side: slew limiter for one motor side (FSM, hold counter, duty reg).
//   clk, rst_n  : clock, async active-low reset
//   tick        : one-cycle ramp strobe
//   estop       : forces duty to 0 on the next edge
//   target      : clamped, masked speed target
//   duty        : registered ramped duty
//   duty_nxt_c  : next-state duty (combinational)
//   hold_nxt_c  : next state is HOLD (combinational)
// Build option: MTR_RAMP_REVERSAL_HOLD_EN enables the zero-duty dwell on
// reversal and after estop release.
module mtr_ramp_side
  import mtr_pkg::*;
#(
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
  parameter int unsigned ZERO_HOLD = 8,
`endif
  parameter int unsigned STEP      = 4
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  tick,
  input  logic  estop,
  input  duty_t target,
  output duty_t duty,
  output duty_t duty_nxt_c,
  output logic  hold_nxt_c
);

  localparam int unsigned EXT_W = DUTY_W + 1;

  ramp_state_t state, state_nxt;

  logic signed [EXT_W-1:0] duty_x, eff_x, step_s, diff, ramped;
  duty_t eff_tgt, duty_step;

`ifdef MTR_RAMP_REVERSAL_HOLD_EN
  localparam int unsigned HOLD_W = 8;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_nxt;
  logic hold_pos, hold_neg, hold_pos_nxt, hold_neg_nxt;
  logic reversing;
  logic sign_match;
`endif

  // One ramp step toward the effective target (0 while reversing with dwell).
  always_comb begin : ramp_calc
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
    reversing = (duty != '0) && (target != '0) &&
                (duty[DUTY_W-1] != target[DUTY_W-1]);
    eff_tgt   = reversing ? '0 : target;
`else
    eff_tgt   = target;
`endif
    duty_x = {duty[DUTY_W-1], duty};
    eff_x  = {eff_tgt[DUTY_W-1], eff_tgt};
    step_s = EXT_W'(STEP);
    diff   = eff_x - duty_x;
    if (diff > step_s) begin
      ramped = duty_x + step_s;
    end else if (diff < -step_s) begin
      ramped = duty_x - step_s;
    end else begin
      ramped = eff_x;
    end
    duty_step = duty_t'(ramped);
  end

  // Next-state / next-duty logic; estop overrides everything.
  always_comb begin : next_state
    state_nxt  = state;
    duty_nxt_c = duty;
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
    hold_cnt_nxt = hold_cnt;
    hold_pos_nxt = hold_pos;
    hold_neg_nxt = hold_neg;
    sign_match   = (hold_pos && !target[DUTY_W-1]) ||
                   (hold_neg &&  target[DUTY_W-1]);
`endif

    case (state)
      TRACK: begin
        if (tick) begin
          duty_nxt_c = duty_step;
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
          if (reversing && (duty_step == '0)) begin
            state_nxt    = HOLD;
            hold_cnt_nxt = '0;
            hold_pos_nxt = ~duty[DUTY_W-1];
            hold_neg_nxt = duty[DUTY_W-1];
          end
`endif
        end
      end
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
      HOLD: begin
        duty_nxt_c = '0;
        // Abandon the dwell if the reversal request went away.
        if ((target == '0) || sign_match) begin
          state_nxt = TRACK;
        end else if (tick) begin
          if (hold_cnt == HOLD_W'(ZERO_HOLD - 1)) begin
            state_nxt = TRACK;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
      end
`endif
      STOP: begin
        duty_nxt_c = '0;
        if (!estop) begin
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
          // No previous direction: dwell runs the full count before restart.
          state_nxt    = HOLD;
          hold_cnt_nxt = '0;
          hold_pos_nxt = 1'b0;
          hold_neg_nxt = 1'b0;
`else
          state_nxt    = TRACK;
`endif
        end
      end
      default: begin
        state_nxt  = TRACK;
        duty_nxt_c = '0;
      end
    endcase

    if (estop) begin
      state_nxt  = STOP;
      duty_nxt_c = '0;
    end

    hold_nxt_c = (state_nxt == HOLD);
  end

  // State, duty and hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= TRACK;
      duty     <= '0;
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
      hold_cnt <= '0;
      hold_pos <= 1'b0;
      hold_neg <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      duty     <= duty_nxt_c;
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
      hold_cnt <= hold_cnt_nxt;
      hold_pos <= hold_pos_nxt;
      hold_neg <= hold_neg_nxt;
`endif
    end
  end

endmodule

// File: rtl/mtr_ramp.sv
// mtr_ramp: slew-rate limiter and reversal guard between PID and mtr_drv.
//   clk, rst_n             : 50 MHz clock, async active-low reset
//   lft_spd_in, rght_spd_in: signed speed demands from PID
//   moving                 : 0 forces both targets to 0
//   estop                  : synchronized bump stop, zeroes duties next edge
//   lft_duty, rght_duty    : ramped duties to mtr_drv
//   at_target              : both sides at clamped target and not dwelling
// Build option: MTR_RAMP_REVERSAL_HOLD_EN enables the zero-duty dwell.
module mtr_ramp
  import mtr_pkg::*;
#(
  parameter int unsigned STEP      = 4,
  parameter int unsigned RAMP_DIV  = 1024,
  parameter int unsigned ZERO_HOLD = 8,
  parameter int unsigned FAST_SIM  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic signed [DUTY_W-1:0] lft_spd_in,
  input  logic signed [DUTY_W-1:0] rght_spd_in,
  input  logic                     moving,
  input  logic                     estop,
  output logic signed [DUTY_W-1:0] lft_duty,
  output logic signed [DUTY_W-1:0] rght_duty,
  output logic                     at_target
);

  localparam int unsigned DIV_N = (FAST_SIM != 0) ? FAST_DIV : RAMP_DIV;
  localparam int unsigned CNT_W = (DIV_N > 1) ? $clog2(DIV_N) : 1;

  if ((STEP < 1) || (STEP > 255) || (ZERO_HOLD < 1) || (ZERO_HOLD > 255) ||
      (DIV_N < 1)) begin : g_bad_cfg
    $error("mtr_ramp: STEP/ZERO_HOLD must be 1..255 and the divider nonzero");
  end

  logic [CNT_W-1:0] tick_cnt;
  logic             tick;
  duty_t            lft_tgt, rght_tgt;
  duty_t            lft_nxt, rght_nxt;
  logic             lft_hold_nxt, rght_hold_nxt;

  // Free-running ramp divider; tick at terminal count.
  assign tick = (tick_cnt == CNT_W'(DIV_N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Clamped, motion-masked targets.
  assign lft_tgt  = clamp_target(lft_spd_in, moving);
  assign rght_tgt = clamp_target(rght_spd_in, moving);

  mtr_ramp_side #(
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
    .ZERO_HOLD (ZERO_HOLD),
`endif
    .STEP      (STEP)
  ) u_lft (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .estop      (estop),
    .target     (lft_tgt),
    .duty       (lft_duty),
    .duty_nxt_c (lft_nxt),
    .hold_nxt_c (lft_hold_nxt)
  );

  mtr_ramp_side #(
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
    .ZERO_HOLD (ZERO_HOLD),
`endif
    .STEP      (STEP)
  ) u_rght (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .estop      (estop),
    .target     (rght_tgt),
    .duty       (rght_duty),
    .duty_nxt_c (rght_nxt),
    .hold_nxt_c (rght_hold_nxt)
  );

  // Registered from next-state values so it aligns with the duty update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      at_target <= 1'b1;
    end else begin
      at_target <= (lft_nxt == lft_tgt) && (rght_nxt == rght_tgt) &&
                   !lft_hold_nxt && !rght_hold_nxt;
    end
  end

endmodule

// File: tb/tb_mtr_ramp.sv
// tb_mtr_ramp: directed scenarios plus randomized stimulus for mtr_ramp,
// checked every cycle against a behavioural per-side model.
module tb_mtr_ramp;

  localparam int STEP      = 4;
  localparam int ZERO_HOLD = 8;
  localparam int DIV       = 16;
`ifdef MTR_RAMP_REVERSAL_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [11:0] lft_spd_in, rght_spd_in;
  logic              moving, estop;
  logic signed [11:0] lft_duty, rght_duty;
  logic              at_target;

  mtr_ramp #(
    .STEP      (STEP),
    .RAMP_DIV  (1024),
    .ZERO_HOLD (ZERO_HOLD),
    .FAST_SIM  (1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .lft_spd_in  (lft_spd_in),
    .rght_spd_in (rght_spd_in),
    .moving      (moving),
    .estop       (estop),
    .lft_duty    (lft_duty),
    .rght_duty   (rght_duty),
    .at_target   (at_target)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_duty[2];
  int m_hold[2];   // dwell ticks still to serve, 0 = not dwelling
  int m_hsign[2];  // direction before the dwell, 0 = none
  bit m_stop[2];
  int m_cyc;
  bit m_at;
  bit m_ticked;

  function automatic int sgn(input int x);
    return (x > 0) ? 1 : ((x < 0) ? -1 : 0);
  endfunction

  function automatic int clampt(input int spd, input bit mv);
    if (!mv) return 0;
    if (spd < -2047) return -2047;
    return spd;
  endfunction

  function automatic int toward(input int d, input int t);
    if (t - d > STEP) return d + STEP;
    if (d - t > STEP) return d - STEP;
    return t;
  endfunction

  function automatic void model_side(input int s, input int t, input bit tk, input bit es);
    int old;
    if (es) begin
      m_stop[s] = 1'b1;
      m_duty[s] = 0;
      m_hold[s] = 0;
    end else if (m_stop[s]) begin
      m_stop[s] = 1'b0;
      m_duty[s] = 0;
      if (HOLD_EN) begin
        m_hold[s]  = ZERO_HOLD;
        m_hsign[s] = 0;
      end
    end else if (m_hold[s] > 0) begin
      if (t == 0 || sgn(t) == m_hsign[s]) m_hold[s] = 0;
      else if (tk) m_hold[s]--;
    end else if (tk) begin
      if (HOLD_EN && m_duty[s] != 0 && t != 0 && sgn(t) != sgn(m_duty[s])) begin
        old = sgn(m_duty[s]);
        m_duty[s] = toward(m_duty[s], 0);
        if (m_duty[s] == 0) begin
          m_hold[s]  = ZERO_HOLD;
          m_hsign[s] = old;
        end
      end else begin
        m_duty[s] = toward(m_duty[s], t);
      end
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int tg0, tg1;
    bit tk;
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        m_duty[s] = 0; m_hold[s] = 0; m_hsign[s] = 0; m_stop[s] = 1'b0;
      end
      m_cyc = 0; m_at = 1'b1; m_ticked = 1'b0;
    end else begin
      tk = ((m_cyc % DIV) == DIV - 1);
      m_cyc++;
      m_ticked = tk;
      tg0 = clampt(int'(lft_spd_in), moving);
      tg1 = clampt(int'(rght_spd_in), moving);
      model_side(0, tg0, tk, estop);
      model_side(1, tg1, tk, estop);
      m_at = (m_duty[0] == tg0) && (m_duty[1] == tg1) &&
             (m_hold[0] == 0) && (m_hold[1] == 0);
    end
  end

  // Continuous comparison on the falling edge.
  bit mon_en = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      check("lft_duty", int'(lft_duty), m_duty[0]);
      check("rght_duty", int'(rght_duty), m_duty[1]);
      check("at_target", int'(at_target), int'(m_at));
    end
  end

  // Count ramp ticks until a side shows `val`; bounded by `bound` cycles.
  task automatic ticks_until(input string tag, input int side, input int val,
                             input int bound, output int nt);
    int cur;
    nt = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (m_ticked) nt++;
      cur = (side == 0) ? int'(lft_duty) : int'(rght_duty);
      if (cur == val) return;
    end
    cur = (side == 0) ? int'(lft_duty) : int'(rght_duty);
    check({tag, "_timeout"}, cur, val);
    nt = -1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int nt, n, v0, v1;
    lft_spd_in = '0; rght_spd_in = '0; moving = 1'b1; estop = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_lft", int'(lft_duty), 0);
    check("rst_rght", int'(rght_duty), 0);
    check("rst_at", int'(at_target), 1);
    mon_en = 1'b1;

    // Simple ramp: 0 -> 100 in 25 ticks.
    rst_n = 1'b1;
    lft_spd_in = 12'sd100;
    ticks_until("lft100", 0, 100, 1000, nt);
    check("lft100_ticks", nt, 25);
    @(negedge clk);
    check("lft100_at", int'(at_target), 1);

    // Reversal +40 -> -40.
    rght_spd_in = 12'sd40;
    ticks_until("rght40", 1, 40, 1000, nt);
    rght_spd_in = -12'sd40;
    ticks_until("rght_rev", 1, -40, 2000, nt);
    check("rght_rev_ticks", nt, HOLD_EN ? 28 : 20);

    // Estop mid tick period, then release.
    lft_spd_in = 12'sd300;
    ticks_until("lft300", 0, 300, 2000, nt);
    repeat (5) @(negedge clk);
    estop = 1'b1;
    @(negedge clk);
    check("estop_lft", int'(lft_duty), 0);
    check("estop_rght", int'(rght_duty), 0);
    repeat (2) @(negedge clk);
    estop = 1'b0;
    ticks_until("estop_rel", 0, 4, 1000, nt);
    check("estop_rel_ticks", nt, HOLD_EN ? 9 : 1);

    // moving=0 from 200 / -200.
    lft_spd_in = 12'sd200; rght_spd_in = -12'sd200;
    ticks_until("lft200", 0, 200, 3000, nt);
    ticks_until("rghtm200", 1, -200, 3000, nt);
    moving = 1'b0;
    ticks_until("mv0", 1, 0, 2000, nt);
    check("mv0_ticks", nt, 50);
    @(negedge clk);
    check("mv0_lft", int'(lft_duty), 0);
    check("mv0_at", int'(at_target), 1);

    // Async reset mid-ramp.
    moving = 1'b1; lft_spd_in = 12'sd500; rght_spd_in = '0;
    repeat (640) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_lft", int'(lft_duty), 0);
    check("arst_at", int'(at_target), 1);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (lft_duty != 0) break;
    end
    check("arst_first_change", n, 16);

    // Most negative demand folds to -2047.
    lft_spd_in = -12'sd2048;
    ticks_until("lftmin", 0, -2047, 12000, nt);
    repeat (40) @(negedge clk);
    check("lftmin_hold", int'(lft_duty), -2047);

    // Randomized traffic, model-checked every cycle.
    for (int k = 0; k < 120; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        lft_spd_in  = 12'($urandom_range(0, 4095));
        rght_spd_in = 12'($urandom_range(0, 4095));
      end else begin
        v0 = int'($urandom_range(0, 600)) - 300;
        v1 = int'($urandom_range(0, 600)) - 300;
        lft_spd_in  = 12'(v0);
        rght_spd_in = 12'(v1);
      end
      moving = ($urandom_range(0, 9) != 0);
      estop  = ($urandom_range(0, 15) == 0);
      repeat ($urandom_range(1, 60)) @(negedge clk);
      estop = 1'b0;
    end
    repeat (20) @(negedge clk);

    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
